// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states,
// decoder jump codes, memory-wait timeout limit and the control bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_JR_WAIT  = 2'b10
    } state_t;

    localparam logic [1:0] JMP_NONE   = 2'b00;
    localparam logic [1:0] JMP_JR     = 2'b01;
    localparam logic [1:0] JMP_JR_FWD = 2'b10;
    localparam logic [1:0] JMP_JAL    = 2'b11;

    // Last wait-counter value tolerated before the memory wait is abandoned.
    localparam logic [3:0] MEM_TIMEOUT_LIMIT = 4'd15;

    localparam int STALL_W = 16;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_stall;
        logic jr_fwd_sel;
        logic mem_timeout;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-status inputs and hazard-control outputs.
// master drives the pipeline status; slave is the hazard controller.
interface pipeline_hazard_ctrl_if;
    import pipe_pkg::*;

    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic               id_uses_rt;
    logic [1:0]         id_jump;
    logic               id_j_jump;
    logic               ex_mem_read;
    logic [4:0]         ex_rt;
    logic               ex_branch_taken;
    logic               mem_req;
    logic               mem_ready;

    logic               pc_write;
    logic               ifid_write;
    logic               ifid_flush;
    logic               idex_flush;
    logic               exmem_stall;
    logic               jr_fwd_sel;
    logic               mem_timeout;
    logic [STALL_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_jump, id_j_jump,
               ex_mem_read, ex_rt, ex_branch_taken, mem_req, mem_ready,
        input  pc_write, ifid_write, ifid_flush, idex_flush,
               exmem_stall, jr_fwd_sel, mem_timeout, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_jump, id_j_jump,
               ex_mem_read, ex_rt, ex_branch_taken, mem_req, mem_ready,
        output pc_write, ifid_write, ifid_flush, idex_flush,
               exmem_stall, jr_fwd_sel, mem_timeout, stall_cycles
    );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
// Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
module load_use_detect (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hazard
);

    assign hazard = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stalls/flushes IF/ID/EX on memory waits,
// taken branches, load-use hazards and jumps; counts stalled cycles.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave bus
);

    state_t             state, next_state;
    logic [3:0]         wait_cnt, wait_cnt_next;
    logic [STALL_W-1:0] stall_cnt;
    logic               hazard;
    ctrl_t              ctrl;

    load_use_detect u_load_use (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_uses_rt  (bus.id_uses_rt),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .hazard      (hazard)
    );

    // State and memory-wait counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= 4'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state and control outputs; RUN conditions are checked in priority order.
    always_comb begin
        ctrl          = CTRL_DEFAULT;
        next_state    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    // Freeze the front end and hold the back end until memory answers.
                    ctrl.pc_write    = 1'b0;
                    ctrl.ifid_write  = 1'b0;
                    ctrl.exmem_stall = 1'b1;
                    next_state       = ST_MEM_WAIT;
                    wait_cnt_next    = 4'd0;
                end else if (bus.ex_branch_taken) begin
                    // Branch wins over load-use: the stalled instruction is squashed anyway.
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                end else if (hazard) begin
                    ctrl.pc_write   = 1'b0;
                    ctrl.ifid_write = 1'b0;
                    ctrl.idex_flush = 1'b1;
                end else if (bus.id_jump == JMP_JR_FWD) begin
                    // Wait one cycle for the forwarded JR target to become available.
                    ctrl.pc_write   = 1'b0;
                    ctrl.ifid_write = 1'b0;
                    ctrl.idex_flush = 1'b1;
                    next_state      = ST_JR_WAIT;
                end else if (bus.id_jump == JMP_JR || bus.id_jump == JMP_JAL || bus.id_j_jump) begin
                    ctrl.ifid_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    next_state = ST_RUN;
                end else if (wait_cnt == MEM_TIMEOUT_LIMIT) begin
                    ctrl.mem_timeout = 1'b1;
                    next_state       = ST_RUN;
                end else begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.ifid_write  = 1'b0;
                    ctrl.exmem_stall = 1'b1;
                    wait_cnt_next    = wait_cnt + 4'd1;
                end
            end
            ST_JR_WAIT: begin
                // Branch and load-use are deliberately not considered here.
                ctrl.jr_fwd_sel = 1'b1;
                ctrl.ifid_flush = 1'b1;
                next_state      = ST_RUN;
            end
            default: begin
                next_state = ST_RUN;
            end
        endcase
        if (reset) begin
            ctrl = '0;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!ctrl.pc_write && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.pc_write     = ctrl.pc_write;
    assign bus.ifid_write   = ctrl.ifid_write;
    assign bus.ifid_flush   = ctrl.ifid_flush;
    assign bus.idex_flush   = ctrl.idex_flush;
    assign bus.exmem_stall  = ctrl.exmem_stall;
    assign bus.jr_fwd_sel   = ctrl.jr_fwd_sel;
    assign bus.mem_timeout  = ctrl.mem_timeout;
    assign bus.stall_cycles = reset ? '0 : stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: single-cycle vector table,
// directed multi-cycle sequences, and randomized traffic against a reference model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output bit order: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_stall, jr_fwd_sel, mem_timeout}
    localparam logic [6:0] O_ZERO = 7'b0000000;
    localparam logic [6:0] O_DEF  = 7'b1100000;
    localparam logic [6:0] O_LU   = 7'b0001000;
    localparam logic [6:0] O_BR   = 7'b1111000;
    localparam logic [6:0] O_JMP  = 7'b1110000;
    localparam logic [6:0] O_FRZ  = 7'b0000100;
    localparam logic [6:0] O_JRW  = 7'b1110010;
    localparam logic [6:0] O_TMO  = 7'b1100001;

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       uses_rt;
        logic [1:0] jump;
        logic       j;
        logic       mrd;
        logic [4:0] ert;
        logic       br, mreq, mrdy;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic ur,
                                logic [1:0] jp, logic j, logic mrd, logic [4:0] ert,
                                logic br, logic mreq, logic mrdy, logic [6:0] exp);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.jump = jp; v.j = j;
        v.mrd = mrd; v.ert = ert; v.br = br; v.mreq = mreq; v.mrdy = mrdy; v.exp = exp;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush,
                bus.exmem_stall, bus.jr_fwd_sel, bus.mem_timeout};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
        bus.id_jump = 2'b00; bus.id_j_jump = 1'b0; bus.ex_mem_read = 1'b0;
        bus.ex_rt = 5'd0; bus.ex_branch_taken = 1'b0; bus.mem_req = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic apply(vec_t v);
        bus.id_rs = v.rs; bus.id_rt = v.rt; bus.id_uses_rt = v.uses_rt;
        bus.id_jump = v.jump; bus.id_j_jump = v.j; bus.ex_mem_read = v.mrd;
        bus.ex_rt = v.ert; bus.ex_branch_taken = v.br; bus.mem_req = v.mreq;
        bus.mem_ready = v.mrdy;
    endtask

    task automatic do_reset(string nm);
        clear_in();
        reset = 1'b1;
        @(negedge clk);
        chk({nm, "_rst_outs"}, 32'(outs()), 32'(O_ZERO));
        tick();
        reset = 1'b0;
    endtask

    // Reference model: tracks which multi-cycle activity is in progress and for how long.
    bit m_in_mem;
    int m_waited;
    bit m_jr_pending;
    int m_stall;

    function automatic logic [6:0] model_step(bit r);
        logic [6:0] e;
        bit lu;
        lu = bus.ex_mem_read && bus.ex_rt != 0 &&
             (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        if (r) begin
            e = O_ZERO;
            m_in_mem = 0; m_jr_pending = 0; m_waited = 0; m_stall = 0;
            return e;
        end
        if (m_jr_pending) begin
            e = O_JRW;
            m_jr_pending = 0;
        end else if (m_in_mem) begin
            if (bus.mem_ready) begin
                e = O_DEF; m_in_mem = 0;
            end else if (m_waited == 15) begin
                e = O_TMO; m_in_mem = 0;
            end else begin
                e = O_FRZ; m_waited++;
            end
        end else if (bus.mem_req && !bus.mem_ready) begin
            e = O_FRZ; m_in_mem = 1; m_waited = 0;
        end else if (bus.ex_branch_taken) begin
            e = O_BR;
        end else if (lu) begin
            e = O_LU;
        end else if (bus.id_jump == 2'b10) begin
            e = O_LU; m_jr_pending = 1;
        end else if (bus.id_jump != 2'b00 || bus.id_j_jump) begin
            e = O_JMP;
        end else begin
            e = O_DEF;
        end
        if (!e[6]) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
        return e;
    endfunction

    initial begin
        logic [6:0] e;
        int stall_before;
        bit r;

        reset = 1'b1;
        clear_in();

        //                name        rs  rt  ur jp     j  mrd ert br mreq mrdy exp
        vecs.push_back(mk("idle",      0,  0, 0, 2'b00, 0, 0,  0, 0, 0,   0,   O_DEF));
        vecs.push_back(mk("lu_rs",     8,  3, 0, 2'b00, 0, 1,  8, 0, 0,   0,   O_LU));
        vecs.push_back(mk("lu_zero",   0,  0, 1, 2'b00, 0, 1,  0, 0, 0,   0,   O_DEF));
        vecs.push_back(mk("lu_rt",     1,  5, 1, 2'b00, 0, 1,  5, 0, 0,   0,   O_LU));
        vecs.push_back(mk("lu_rt_nu",  1,  5, 0, 2'b00, 0, 1,  5, 0, 0,   0,   O_DEF));
        vecs.push_back(mk("no_load",   8,  8, 1, 2'b00, 0, 0,  8, 0, 0,   0,   O_DEF));
        vecs.push_back(mk("branch",    0,  0, 0, 2'b00, 0, 0,  0, 1, 0,   0,   O_BR));
        vecs.push_back(mk("br_lu",     8,  0, 0, 2'b00, 0, 1,  8, 1, 0,   0,   O_BR));
        vecs.push_back(mk("jr",        0,  0, 0, 2'b01, 0, 0,  0, 0, 0,   0,   O_JMP));
        vecs.push_back(mk("jal",       0,  0, 0, 2'b11, 0, 0,  0, 0, 0,   0,   O_JMP));
        vecs.push_back(mk("j",         0,  0, 0, 2'b00, 1, 0,  0, 0, 0,   0,   O_JMP));
        vecs.push_back(mk("jr_fwd",    0,  0, 0, 2'b10, 0, 0,  0, 0, 0,   0,   O_LU));
        vecs.push_back(mk("mem_rdy",   0,  0, 0, 2'b00, 0, 0,  0, 0, 1,   1,   O_DEF));
        vecs.push_back(mk("mem_br",    8,  0, 0, 2'b00, 0, 1,  8, 1, 1,   0,   O_FRZ));
        vecs.push_back(mk("br_jal",    0,  0, 0, 2'b11, 1, 0,  0, 1, 0,   0,   O_BR));

        foreach (vecs[i]) begin
            do_reset(vecs[i].name);
            apply(vecs[i]);
            @(negedge clk);
            chk({vecs[i].name, "_outs"}, 32'(outs()), 32'(vecs[i].exp));
            tick();
            clear_in();
            @(negedge clk);
            chk({vecs[i].name, "_stall"}, 32'(bus.stall_cycles), vecs[i].exp[6] ? 32'd0 : 32'd1);
        end

        // Load-use on rs: one stall cycle, counter advances to 1.
        do_reset("lu_seq");
        bus.ex_mem_read = 1; bus.ex_rt = 8; bus.id_rs = 8;
        @(negedge clk);
        chk("lu_seq_c1", 32'(outs()), 32'(O_LU));
        tick();
        clear_in();
        @(negedge clk);
        chk("lu_seq_c2", 32'(outs()), 32'(O_DEF));
        chk("lu_seq_cnt", 32'(bus.stall_cycles), 32'd1);
        tick();

        // Memory wait: three frozen cycles, released on the fourth.
        do_reset("mw");
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mw_frz%0d", c), 32'(outs()), 32'(O_FRZ));
            tick();
        end
        bus.mem_ready = 1;
        @(negedge clk);
        chk("mw_release", 32'(outs()), 32'(O_DEF));
        tick();
        clear_in();
        @(negedge clk);
        chk("mw_run", 32'(outs()), 32'(O_DEF));
        chk("mw_cnt", 32'(bus.stall_cycles), 32'd3);
        tick();

        // Timeout: pulse on the 17th cycle after entry, then back in RUN.
        do_reset("tmo");
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            chk($sformatf("tmo_c%0d", c), 32'(outs()), (c == 17) ? 32'(O_TMO) : 32'(O_FRZ));
            tick();
        end
        bus.mem_req = 0;
        @(negedge clk);
        chk("tmo_after", 32'(outs()), 32'(O_DEF));
        chk("tmo_cnt", 32'(bus.stall_cycles), 32'd16);
        tick();

        // JR-forwarded: stall, then forwarded-target cycle ignoring branch/load-use, then default.
        do_reset("jrf");
        bus.id_jump = 2'b10;
        @(negedge clk);
        chk("jrf_stall", 32'(outs()), 32'(O_LU));
        tick();
        bus.id_jump = 2'b00; bus.ex_branch_taken = 1;
        bus.ex_mem_read = 1; bus.ex_rt = 4; bus.id_rs = 4;
        @(negedge clk);
        chk("jrf_sel", 32'(outs()), 32'(O_JRW));
        tick();
        clear_in();
        @(negedge clk);
        chk("jrf_done", 32'(outs()), 32'(O_DEF));
        chk("jrf_cnt", 32'(bus.stall_cycles), 32'd1);
        tick();

        // Reset in the middle of a memory wait aborts it without a timeout.
        do_reset("rmw");
        bus.mem_req = 1; bus.mem_ready = 0;
        tick(); tick(); tick();
        reset = 1;
        @(negedge clk);
        chk("rmw_outs", 32'(outs()), 32'(O_ZERO));
        chk("rmw_cnt", 32'(bus.stall_cycles), 32'd0);
        tick();
        reset = 0; bus.mem_req = 0;
        @(negedge clk);
        chk("rmw_run", 32'(outs()), 32'(O_DEF));
        chk("rmw_cnt0", 32'(bus.stall_cycles), 32'd0);
        tick();

        // Reset in JR_WAIT: no forwarded-target cycle afterwards.
        do_reset("rjr");
        bus.id_jump = 2'b10;
        tick();
        bus.id_jump = 2'b00;
        reset = 1;
        @(negedge clk);
        chk("rjr_outs", 32'(outs()), 32'(O_ZERO));
        tick();
        reset = 0;
        @(negedge clk);
        chk("rjr_run", 32'(outs()), 32'(O_DEF));
        tick();

        // Randomized traffic against the reference model.
        do_reset("rnd");
        m_in_mem = 0; m_waited = 0; m_jr_pending = 0; m_stall = 0;
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 59) == 0);
            reset = r;
            bus.id_rs           = 5'($urandom_range(0, 3));
            bus.id_rt           = 5'($urandom_range(0, 3));
            bus.id_uses_rt      = 1'($urandom_range(0, 1));
            bus.id_jump         = 2'($urandom_range(0, 3));
            bus.id_j_jump       = ($urandom_range(0, 3) == 0);
            bus.ex_mem_read     = 1'($urandom_range(0, 1));
            bus.ex_rt           = 5'($urandom_range(0, 3));
            bus.ex_branch_taken = ($urandom_range(0, 3) == 0);
            bus.mem_req         = ($urandom_range(0, 5) == 0);
            bus.mem_ready       = m_in_mem ? ($urandom_range(0, 9) == 0) : 1'($urandom_range(0, 1));
            stall_before = m_stall;
            e = model_step(r);
            @(negedge clk);
            chk($sformatf("rnd%0d_outs", n), 32'(outs()), 32'(e));
            chk($sformatf("rnd%0d_cnt", n), 32'(bus.stall_cycles), r ? 32'd0 : 32'(stall_before));
            tick();
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
